hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller sitting directly downstream of the RAW detector in the ID stage. It turns the per-operand RAW flags into forwarding selects, registered into EX, and into stall, bubble and flush controls for the pipeline registers. It also tracks the multi-cycle multiply/divide unit (MDU) so HI/LO consumers wait. It freezes the whole pipeline while a data-memory access is outstanding.

## Interface
Parameters:
- MDU_CYCLES, 32, cycles the MDU is busy after a mult/div issues (≥1)
- CNT_W, 6, MDU counter width; must hold MDU_CYCLES

Ports:
- clk  in  1  single pipeline clock
- rst_n  in  1  reset, asynchronous, active-low
- raw  in  raw_t  {rs_mem, rs_wbu, rt_mem, rt_wbu} from the RAW detector for the ID instruction
- id_valid  in  1  ID holds a valid instruction
- ex_is_load  in  1  instruction now in EX is a load
- id_mdu_start  in  1  ID instruction is mult/multu/div/divu
- id_uses_hilo  in  1  ID instruction reads or writes HI/LO (mfhi/mflo/mthi/mtlo)
- mem_req  in  1  MEM stage has a data-memory access this cycle
- dmem_ready  in  1  data memory completes the MEM access this cycle
- branch_taken  in  1  EX resolved a taken branch/jump (redirect)
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline register enables
- if_id_flush  out  1  clear IF/ID to NOP
- id_ex_bubble  out  1  load NOP into ID/EX
- fwd_rs_ex, fwd_rt_ex  out  2 each  EX operand source: 00 register file, 01 MEM result, 10 WBU result
- mdu_busy  out  1  MDU counter non-zero
- stall_cnt  out  32  performance counter of cycles with pc_en=0

## Operation
- freeze = mem_req & !dmem_ready. While freeze is high, all five enables are 0, flush and bubble are 0, and registered state holds. The MDU counter is the only exception.
- load_use = id_valid & ex_is_load & (raw.rs_mem | raw.rt_mem).
- hilo_wait = id_valid & mdu_busy & (id_uses_hilo | id_mdu_start).
- stall_id = load_use | hilo_wait.
- Priority when not frozen: branch_taken > stall_id > normal.
  - branch_taken: all enables 1; if_id_flush=1; id_ex_bubble=1. The ID instruction is killed and its stalls are ignored.
  - stall_id: pc_en=0, if_id_en=0, id_ex_en=1 with id_ex_bubble=1; ex_mem_en and mem_wb_en are 1.
  - normal: all enables 1; flush and bubble are 0.
- advance = id_valid & !freeze & !branch_taken & !stall_id. This is the ID→EX transfer of a real instruction.
- Forward select, computed per operand in ID:
  - MEM flag set → 01.
  - else WBU flag set → 10.
  - else 00.
  - MEM has priority over WBU (newest producer wins).
- fwd_*_ex register update, when not frozen:
  - advance: load the computed value.
  - bubble or flush: load 00.
- Load-use resolves without extra state. After one bubble the load reaches MEM, the RAW detector reports the WBU flag, and the forward select is 10.
- MDU counter:
  - advance & id_mdu_start loads MDU_CYCLES.
  - Otherwise it decrements by 1 while non-zero and saturates at 0.
  - It counts every cycle, including during freeze, because the MDU runs independently.
  - mdu_busy = (count != 0).
- stall_cnt increments by 1 on every cycle with pc_en=0 and wraps at 2^32.

## Timing
- Reset values: fwd_rs_ex=00, fwd_rt_ex=00, MDU count 0, mdu_busy=0, stall_cnt=0. Combinational outputs follow inputs; with all inputs 0, the enables are 1.
- Enables, flush and bubble are combinational, in the same cycle as their inputs.
- fwd_*_ex is valid the cycle after advance, aligned with the instruction in EX.
- Latencies:
  - load-use costs exactly 1 bubble.
  - Each freeze cycle costs 1 cycle.
  - A HI/LO consumer waits until mdu_busy falls, at most MDU_CYCLES cycles.
- mdu_busy rises the cycle after the issuing advance and stays high for exactly MDU_CYCLES cycles.
- A second MDU op behind a busy one stalls until the count reaches 0, then issues and reloads.
- Reset asserted mid-operation clears all state immediately. There are no pending stalls after release.
- Simultaneous events:
  - freeze & branch_taken: freeze wins. The branch is re-seen when EX is released.
  - branch_taken & id_mdu_start: the counter is not loaded.

## Test plan
- raw.rs_mem=1, ex_is_load=0, id_valid=1 → no stall; fwd_rs_ex=01 next cycle. With rs_mem & rs_wbu both set → 01.
- raw.rt_mem=1, ex_is_load=1 → one cycle pc_en=0, id_ex_bubble=1, stall_cnt+1. Next cycle rt_wbu=1 → advance, fwd_rt_ex=10.
- mult issues (MDU_CYCLES=4), then mflo in ID → mdu_busy high for 4 cycles; mflo stalls until busy=0; stall_cnt increases by the number of stall cycles.
- mem_req=1, dmem_ready=0 for 3 cycles while load_use is pending → all enables 0 for 3 cycles; fwd regs hold; MDU count still decrements.
- branch_taken=1 together with load_use=1 and id_mdu_start=1 → if_id_flush=1, id_ex_bubble=1, pc_en=1; fwd_*_ex=00; MDU count unchanged.
- rst_n low mid-MDU (count=3) and mid-stall → mdu_busy=0, fwd=00, stall_cnt=0 immediately, asynchronously.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - ID-stage hazard controller: forwarding selects, stall/bubble/flush, MDU busy tracking
typedef struct packed {
  logic rs_mem;
  logic rs_wbu;
  logic rt_mem;
  logic rt_wbu;
} raw_t;

module hazard_ctrl #(
  parameter int MDU_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  raw_t        raw,
  input  logic        id_valid,
  input  logic        ex_is_load,
  input  logic        id_mdu_start,
  input  logic        id_uses_hilo,
  input  logic        mem_req,
  input  logic        dmem_ready,
  input  logic        branch_taken,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic [1:0]  fwd_rs_ex,
  output logic [1:0]  fwd_rt_ex,
  output logic        mdu_busy,
  output logic [31:0] stall_cnt
);

  logic             freeze;
  logic             load_use;
  logic             hilo_wait;
  logic             stall_id;
  logic             advance;
  logic [CNT_W-1:0] mdu_cnt;
  logic [1:0]       fwd_rs_id;
  logic [1:0]       fwd_rt_id;

  // The newest producer (MEM) wins over the older one (WBU).
  function automatic logic [1:0] fwd_sel(input logic from_mem, input logic from_wbu);
    if (from_mem)      return 2'b01;
    else if (from_wbu) return 2'b10;
    else               return 2'b00;
  endfunction

  assign freeze    = mem_req & ~dmem_ready;
  assign mdu_busy  = (mdu_cnt != '0);
  assign load_use  = id_valid & ex_is_load & (raw.rs_mem | raw.rt_mem);
  assign hilo_wait = id_valid & mdu_busy & (id_uses_hilo | id_mdu_start);
  assign stall_id  = load_use | hilo_wait;
  assign advance   = id_valid & ~freeze & ~branch_taken & ~stall_id;
  assign fwd_rs_id = fwd_sel(raw.rs_mem, raw.rs_wbu);
  assign fwd_rt_id = fwd_sel(raw.rt_mem, raw.rt_wbu);

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (freeze) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (stall_id) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  // Anything entering EX that is not a real advancing instruction carries no forwarding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_rs_ex <= 2'b00;
      fwd_rt_ex <= 2'b00;
    end else if (!freeze) begin
      fwd_rs_ex <= advance ? fwd_rs_id : 2'b00;
      fwd_rt_ex <= advance ? fwd_rt_id : 2'b00;
    end
  end

  // The MDU runs on its own, so its countdown ignores freeze.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdu_cnt <= '0;
    end else if (advance && id_mdu_start) begin
      mdu_cnt <= CNT_W'(MDU_CYCLES);
    end else if (mdu_cnt != '0) begin
      mdu_cnt <= mdu_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!pc_en) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl against a behavioural model
module tb_hazard_ctrl;

  localparam int MDU = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  raw_v;
  logic        id_valid, ex_is_load, id_mdu_start, id_uses_hilo;
  logic        mem_req, dmem_ready, branch_taken;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_bubble, mdu_busy;
  logic [1:0]  fwd_rs_ex, fwd_rt_ex;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.MDU_CYCLES(MDU), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .raw(raw_v), .id_valid(id_valid), .ex_is_load(ex_is_load),
    .id_mdu_start(id_mdu_start), .id_uses_hilo(id_uses_hilo), .mem_req(mem_req),
    .dmem_ready(dmem_ready), .branch_taken(branch_taken), .pc_en(pc_en), .if_id_en(if_id_en),
    .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .fwd_rs_ex(fwd_rs_ex),
    .fwd_rt_ex(fwd_rt_ex), .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
  );

  int          n_pass = 0;
  int          n_total = 0;
  logic [1:0]  m_fwd_rs = 2'b00;
  logic [1:0]  m_fwd_rt = 2'b00;
  int          m_mdu = 0;
  logic [31:0] m_stall = 32'd0;
  logic [31:0] s0;
  int          busy_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [1:0] pick(input logic from_mem, input logic from_wbu);
    if (from_mem) return 2'd1;
    if (from_wbu) return 2'd2;
    return 2'd0;
  endfunction

  // en = {pc, if_id, id_ex, ex_mem, mem_wb}
  task automatic model_comb(output logic [4:0] en, output logic fl, output logic bu,
                            output logic adv, output logic frz);
    logic must_wait;
    frz = mem_req && !dmem_ready;
    must_wait = id_valid && ((ex_is_load && (raw_v[3] || raw_v[1])) ||
                             (m_mdu > 0 && (id_uses_hilo || id_mdu_start)));
    en = 5'b11111; fl = 1'b0; bu = 1'b0;
    if (frz) en = 5'b00000;
    else if (branch_taken) begin fl = 1'b1; bu = 1'b1; end
    else if (must_wait) begin en = 5'b00111; bu = 1'b1; end
    adv = id_valid && !frz && !branch_taken && !must_wait;
  endtask

  task automatic compare_all();
    logic [4:0] en; logic fl, bu, adv, frz;
    model_comb(en, fl, bu, adv, frz);
    chk("pc_en", pc_en, en[4]);
    chk("if_id_en", if_id_en, en[3]);
    chk("id_ex_en", id_ex_en, en[2]);
    chk("ex_mem_en", ex_mem_en, en[1]);
    chk("mem_wb_en", mem_wb_en, en[0]);
    chk("if_id_flush", if_id_flush, fl);
    chk("id_ex_bubble", id_ex_bubble, bu);
    chk("fwd_rs_ex", fwd_rs_ex, m_fwd_rs);
    chk("fwd_rt_ex", fwd_rt_ex, m_fwd_rt);
    chk("mdu_busy", mdu_busy, m_mdu > 0);
    chk("stall_cnt", stall_cnt, m_stall);
  endtask

  task automatic apply(input logic [3:0] r, input logic v, input logic ld, input logic ms,
                       input logic uh, input logic mr, input logic dr, input logic br);
    logic [4:0] en; logic fl, bu, adv, frz;
    raw_v = r; id_valid = v; ex_is_load = ld; id_mdu_start = ms;
    id_uses_hilo = uh; mem_req = mr; dmem_ready = dr; branch_taken = br;
    #1;
    compare_all();
    @(posedge clk);
    model_comb(en, fl, bu, adv, frz);
    if (!frz) begin
      m_fwd_rs = adv ? pick(raw_v[3], raw_v[2]) : 2'b00;
      m_fwd_rt = adv ? pick(raw_v[1], raw_v[0]) : 2'b00;
    end
    if (adv && id_mdu_start) m_mdu = MDU;
    else if (m_mdu > 0) m_mdu--;
    if (!en[4]) m_stall++;
    #1;
  endtask

  task automatic idle();
    apply(4'b0000, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    raw_v = 4'b0; id_valid = 0; ex_is_load = 0; id_mdu_start = 0;
    id_uses_hilo = 0; mem_req = 0; dmem_ready = 0; branch_taken = 0;
    #2;
    chk("rst_fwd_rs", fwd_rs_ex, 2'b00);
    chk("rst_fwd_rt", fwd_rt_ex, 2'b00);
    chk("rst_busy", mdu_busy, 1'b0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_enables", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 5'b11111);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Forwarding selects, including MEM-over-WBU priority and an invalid ID slot
    apply(4'b1000, 1, 0, 0, 0, 0, 0, 0);
    chk("fwd_rs_mem", fwd_rs_ex, 2'd1);
    apply(4'b1100, 1, 0, 0, 0, 0, 0, 0);
    chk("fwd_rs_mem_over_wbu", fwd_rs_ex, 2'd1);
    apply(4'b0100, 1, 0, 0, 0, 0, 0, 0);
    chk("fwd_rs_wbu", fwd_rs_ex, 2'd2);
    apply(4'b0011, 1, 0, 0, 0, 0, 0, 0);
    chk("fwd_rt_mem_over_wbu", fwd_rt_ex, 2'd1);
    apply(4'b1000, 0, 0, 0, 0, 0, 0, 0);
    chk("fwd_invalid_id", fwd_rs_ex, 2'd0);

    // Load-use: one bubble, then WBU forwarding
    s0 = m_stall;
    apply(4'b0010, 1, 1, 0, 0, 0, 0, 0);
    apply(4'b0001, 1, 0, 0, 0, 0, 0, 0);
    chk("lu_fwd_rt_wbu", fwd_rt_ex, 2'd2);
    chk("lu_stall_delta", stall_cnt - s0, 32'd1);

    // mult then mflo: four busy cycles, four stall cycles
    apply(4'b0000, 1, 0, 1, 0, 0, 0, 0);
    s0 = m_stall;
    busy_seen = 0;
    for (int i = 0; i < 5; i++) begin
      busy_seen += int'(mdu_busy);
      apply(4'b0000, 1, 0, 0, 1, 0, 0, 0);
    end
    chk("mdu_busy_cycles", busy_seen, 32'd4);
    chk("mdu_stall_delta", stall_cnt - s0, 32'd4);
    chk("mdu_idle_after", mdu_busy, 1'b0);

    // Freeze over a pending load-use while the MDU keeps counting
    apply(4'b1000, 1, 0, 1, 0, 0, 0, 0);
    s0 = m_stall;
    for (int i = 0; i < 3; i++) apply(4'b0010, 1, 1, 0, 0, 1, 0, 0);
    chk("frz_fwd_hold", fwd_rs_ex, 2'd1);
    chk("frz_stall_delta", stall_cnt - s0, 32'd3);
    chk("frz_mdu_still_busy", mdu_busy, 1'b1);
    apply(4'b0010, 1, 1, 0, 0, 1, 1, 0);
    chk("frz_mdu_drained", mdu_busy, 1'b0);
    apply(4'b0001, 1, 0, 0, 0, 0, 0, 0);
    chk("frz_then_fwd_rt", fwd_rt_ex, 2'd2);
    apply(4'b0000, 1, 0, 0, 0, 1, 0, 1);
    idle();

    // Branch beats load-use and blocks the MDU load
    apply(4'b1010, 1, 1, 1, 0, 0, 0, 1);
    chk("br_fwd_rs", fwd_rs_ex, 2'd0);
    chk("br_fwd_rt", fwd_rt_ex, 2'd0);
    chk("br_no_mdu", mdu_busy, 1'b0);
    idle();

    // Asynchronous reset mid-MDU (count 3) and mid-stall
    apply(4'b1000, 1, 0, 1, 0, 0, 0, 0);
    apply(4'b0001, 1, 0, 0, 0, 0, 0, 0);
    raw_v = 4'b0010; id_valid = 1; ex_is_load = 1;
    #1;
    chk("pre_rst_stall", pc_en, 1'b0);
    chk("pre_rst_busy", mdu_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", mdu_busy, 1'b0);
    chk("arst_fwd_rs", fwd_rs_ex, 2'd0);
    chk("arst_fwd_rt", fwd_rt_ex, 2'd0);
    chk("arst_stall_cnt", stall_cnt, 32'd0);
    m_fwd_rs = 2'b00; m_fwd_rt = 2'b00; m_mdu = 0; m_stall = 32'd0;
    raw_v = 4'b0; id_valid = 0; ex_is_load = 0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    idle();
    apply(4'b0000, 1, 0, 0, 1, 0, 0, 0);
    chk("post_rst_no_stall", stall_cnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
